fft_frame_scheduler: RTL and testbench

Read-side controller for the 1024-entry audio sample buffer, in the `mclk` domain. It watches the buffer's published top-of-buffer address and decides when a new analysis frame is due. It then sequences `FRAME_LEN` contiguous buffer reads and streams the samples to the FFT input with start/end-of-frame markers and valid/ready backpressure. It is the only master of the buffer read port.

---
 rtl/fft_frame_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// Read-side frame scheduler for the 1024-entry sample buffer: triggers frames on HOP new samples and streams them to the FFT.
// Optional sticky overrun detector enabled by defining FFT_SCHED_OVERRUN_DET_EN.
module fft_frame_scheduler #(
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int DATA_BITS = 16
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic [9:0]           buff_top_i,
    input  logic                 buffer_available_i,
    output logic [9:0]           buffer_raddr_o,
    input  logic [DATA_BITS-1:0] buffer_rdata_i,
    input  logic                 enable_i,
    output logic [DATA_BITS-1:0] sample_o,
    output logic                 sample_valid_o,
    input  logic                 sample_ready_i,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int            CW       = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        READ,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [9:0]           last_top;
    logic [9:0]           new_cnt;
    logic [9:0]           frame_start;
    logic [CW-1:0]        rd_cnt;
    logic                 arm_go;
    logic                 fire;
    logic                 issue;
    logic                 last_issue;
    logic [1:0]           occ;
    logic                 inflight;
    logic                 inflight_sop;
    logic                 inflight_eop;
    logic [DATA_BITS-1:0] skid_data;
    logic                 skid_sop;
    logic                 skid_eop;
    logic                 skid_valid;

    assign new_cnt     = buff_top_i - last_top;
    assign arm_go      = (buff_top_i >= 10'(FRAME_LEN - 1));
    assign frame_start = buff_top_i - 10'(FRAME_LEN - 1);
    assign fire        = sample_valid_o && sample_ready_i;
    assign busy_o      = (state != IDLE);

    // Read credit: data in flight from the buffer plus samples held locally may never exceed two.
    assign occ        = 2'(inflight) + 2'(sample_valid_o) + 2'(skid_valid);
    assign issue      = (state == READ) && ((occ - 2'(fire)) < 2'd2);
    assign last_issue = issue && (rd_cnt == LAST_IDX);

    always_comb begin
        // NOTE: state_nxt gets a default before the case so no branch can leave it unassigned and infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i && buffer_available_i && (new_cnt >= 10'(HOP))) state_nxt = ARM;
            ARM:     state_nxt = arm_go ? READ : IDLE;
            READ:    if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (fire && eop_o) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        // NOTE: non-blocking assignments throughout so every register sees the values from before the edge.
        if (!rst_n) begin
            state          <= IDLE;
            last_top       <= '0;
            buffer_raddr_o <= '0;
            rd_cnt         <= '0;
            inflight       <= 1'b0;
            inflight_sop   <= 1'b0;
            inflight_eop   <= 1'b0;
        end else begin
            state        <= state_nxt;
            inflight     <= issue;
            inflight_sop <= issue && (rd_cnt == '0);
            inflight_eop <= last_issue;
            if (state == ARM && arm_go) begin
                buffer_raddr_o <= frame_start;
                last_top       <= buff_top_i;
                rd_cnt         <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + CW'(1);
                // The address parks on the frame's last sample once it has been read.
                if (!last_issue) buffer_raddr_o <= buffer_raddr_o + 10'd1;
            end
        end
    end

    // Two-entry output queue: sample_o is the head, skid catches buffer data that lands during a stall.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sample_o       <= '0;
            sop_o          <= 1'b0;
            eop_o          <= 1'b0;
            sample_valid_o <= 1'b0;
            skid_data      <= '0;
            skid_sop       <= 1'b0;
            skid_eop       <= 1'b0;
            skid_valid     <= 1'b0;
        end else if (!sample_valid_o || fire) begin
            if (skid_valid) begin
                sample_o       <= skid_data;
                sop_o          <= skid_sop;
                eop_o          <= skid_eop;
                sample_valid_o <= 1'b1;
                skid_valid     <= inflight;
                skid_data      <= buffer_rdata_i;
                skid_sop       <= inflight_sop;
                skid_eop       <= inflight_eop;
            end else if (inflight) begin
                sample_o       <= buffer_rdata_i;
                sop_o          <= inflight_sop;
                eop_o          <= inflight_eop;
                sample_valid_o <= 1'b1;
            end else begin
                sample_valid_o <= 1'b0;
                sop_o          <= 1'b0;
                eop_o          <= 1'b0;
            end
        end else if (inflight) begin
            skid_data  <= buffer_rdata_i;
            skid_sop   <= inflight_sop;
            skid_eop   <= inflight_eop;
            skid_valid <= 1'b1;
        end
    end

`ifdef FFT_SCHED_OVERRUN_DET_EN
    logic [9:0] start_addr;
    logic [9:0] top_ahead;

    // Once the writer is within FRAME_LEN of lapping the frame start, unread samples may be gone.
    assign top_ahead = buff_top_i - start_addr;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            start_addr <= '0;
            overrun_o  <= 1'b0;
        end else begin
            if (state == ARM && arm_go) start_addr <= frame_start;
            if ((state == READ || state == DRAIN) && (top_ahead >= 10'(1024 - FRAME_LEN)))
                overrun_o <= 1'b1;
        end
    end
`else
    assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: vector table plus a sample scoreboard fed by a buffer model.
module tb_fft_frame_scheduler;

    localparam int F = 256;

`ifdef FFT_SCHED_OVERRUN_DET_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  buff_top_i = '0;
    logic        buffer_available_i = 1'b0;
    logic [9:0]  buffer_raddr_o;
    logic [15:0] buffer_rdata_i;
    logic        enable_i = 1'b0;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i = 1'b1;
    logic        sop_o;
    logic        eop_o;
    logic        busy_o;
    logic        overrun_o;

    fft_frame_scheduler #(.FRAME_LEN(F), .HOP(128), .DATA_BITS(16)) dut (
        .mclk               (mclk),
        .rst_n              (rst_n),
        .buff_top_i         (buff_top_i),
        .buffer_available_i (buffer_available_i),
        .buffer_raddr_o     (buffer_raddr_o),
        .buffer_rdata_i     (buffer_rdata_i),
        .enable_i           (enable_i),
        .sample_o           (sample_o),
        .sample_valid_o     (sample_valid_o),
        .sample_ready_i     (sample_ready_i),
        .sop_o              (sop_o),
        .eop_o              (eop_o),
        .busy_o             (busy_o),
        .overrun_o          (overrun_o)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } item_t;

    typedef struct {
        logic [9:0] top;
        logic       en;
        logic       frame;
        int         rmode;
    } vec_t;

    item_t      sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         acc_cnt = 0;
    int         ready_mode = 0;
    logic [9:0] exp_raddr = '0;
    vec_t       vt[13];

    function automatic logic [15:0] buf_word(input logic [9:0] a);
        return ({6'd0, a} * 16'd97) ^ 16'hC35A;
    endfunction

    // Buffer model: one-cycle synchronous read.
    always @(posedge mclk) buffer_rdata_i <= buf_word(buffer_raddr_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [9:0] top);
        item_t      it;
        logic [9:0] a;
        for (int i = 0; i < F; i++) begin
            a       = top - 10'(F - 1) + 10'(i);
            it.data = buf_word(a);
            it.sop  = (i == 0);
            it.eop  = (i == F - 1);
            sb.push_back(it);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while ((sb.size() != 0 || busy_o) && n < budget);
        check(name, 64'(sb.size() != 0 || busy_o), 64'd0);
    endtask

    task automatic do_reset();
        enable_i           = 1'b0;
        buff_top_i         = '0;
        buffer_available_i = 1'b0;
        @(negedge mclk);
        rst_n = 1'b0;
        sb.delete();
        exp_raddr = '0;
        repeat (3) @(negedge mclk);
        check("reset_values", 64'({buffer_raddr_o, sample_o, sample_valid_o, sop_o, eop_o, busy_o, overrun_o}), 64'd0);
        rst_n = 1'b1;
    endtask

    // Ready pattern generator: 0 = always ready, 1 = toggling, 2 = random.
    initial forever begin
        @(posedge mclk);
        #1;
        case (ready_mode)
            0:       sample_ready_i = 1'b1;
            1:       sample_ready_i = ~sample_ready_i;
            default: sample_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: every valid cycle must show the head of the queue; stalled samples must not move.
    always @(negedge mclk) begin
        if (rst_n && sample_valid_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_sample: got %0h sop=%0b eop=%0b, expected no sample", sample_o, sop_o, eop_o);
            end else begin
                check("sample", 64'({sample_o, sop_o, eop_o}), 64'(sb[0]));
                if (sample_ready_i) begin
                    sb.delete(0);
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        int n;
        int first_busy;
        int busy_cnt;
        logic [9:0] raddr_at2;

        vt[0]  = '{10'd200,  1'b1, 1'b0, 0};
        vt[1]  = '{10'd383,  1'b1, 1'b1, 0};
        vt[2]  = '{10'd400,  1'b1, 1'b0, 0};
        vt[3]  = '{10'd511,  1'b1, 1'b1, 1};
        vt[4]  = '{10'd700,  1'b0, 1'b0, 0};
        vt[5]  = '{10'd700,  1'b1, 1'b1, 1};
        vt[6]  = '{10'd1000, 1'b1, 1'b1, 2};
        vt[7]  = '{10'd100,  1'b1, 1'b0, 0};
        vt[8]  = '{10'd104,  1'b1, 1'b0, 0};
        vt[9]  = '{10'd300,  1'b1, 1'b1, 0};
        vt[10] = '{10'd1023, 1'b1, 1'b1, 2};
        vt[11] = '{10'd254,  1'b1, 1'b0, 0};
        vt[12] = '{10'd255,  1'b1, 1'b1, 1};

        // Basic frame: address timing and busy length with ready held high.
        do_reset();
        ready_mode = 0;
        enable_i   = 1'b1;
        @(posedge mclk);
        #1;
        buff_top_i         = 10'd300;
        buffer_available_i = 1'b1;
        push_frame(10'd300);
        first_busy = -1;
        busy_cnt   = 0;
        raddr_at2  = '0;
        n          = 0;
        while (n < 600) begin
            @(negedge mclk);
            if (n == 2) raddr_at2 = buffer_raddr_o;
            if (busy_o) begin
                if (first_busy < 0) first_busy = n;
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                break;
            end
            n++;
        end
        check("busy_rise_cycle", 64'(first_busy), 64'd1);
        check("first_raddr", 64'(raddr_at2), 64'd45);
        check("busy_length", 64'(busy_cnt), 64'(F + 3));
        check("basic_drained", 64'(sb.size()), 64'd0);
        check("basic_raddr_park", 64'(buffer_raddr_o), 64'd300);

        // Vector table: trigger / no-trigger decisions across hop, wrap and low-top boundaries.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            ready_mode = vt[i].rmode;
            enable_i   = vt[i].en;
            acc_cnt    = 0;
            @(posedge mclk);
            #1;
            buff_top_i         = vt[i].top;
            buffer_available_i = (vt[i].top != 10'd0);
            if (vt[i].frame) begin
                push_frame(vt[i].top);
                wait_done(4000, "frame_done");
                exp_raddr = vt[i].top;
            end else begin
                repeat (16) @(negedge mclk);
            end
            check("accepted", 64'(acc_cnt), vt[i].frame ? 64'(F) : 64'd0);
            check("raddr_hold", 64'(buffer_raddr_o), 64'(exp_raddr));
            check("overrun_clear", 64'(overrun_o), 64'd0);
        end

        // Mid-frame reset at sample 100, then a clean frame with sop first.
        do_reset();
        ready_mode = 0;
        enable_i   = 1'b1;
        acc_cnt    = 0;
        @(posedge mclk);
        #1;
        buff_top_i         = 10'd300;
        buffer_available_i = 1'b1;
        push_frame(10'd300);
        n = 0;
        while (acc_cnt < 100 && n < 1000) begin
            @(negedge mclk);
            n++;
        end
        check("reached_sample_100", 64'(acc_cnt >= 100), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midframe_reset_outputs",
              64'({buffer_raddr_o, sample_o, sample_valid_o, sop_o, eop_o, busy_o, overrun_o}), 64'd0);
        push_frame(10'd300);
        acc_cnt = 0;
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        wait_done(4000, "restart_frame_done");
        check("restart_accepted", 64'(acc_cnt), 64'(F));

        // Overrun: the writer runs 900 past the frame start while the frame is still streaming.
        do_reset();
        ready_mode = 1;
        enable_i   = 1'b1;
        acc_cnt    = 0;
        @(posedge mclk);
        #1;
        buff_top_i         = 10'd300;
        buffer_available_i = 1'b1;
        push_frame(10'd300);
        repeat (40) @(negedge mclk);
        check("overrun_before", 64'(overrun_o), 64'd0);
        enable_i   = 1'b0;
        buff_top_i = 10'd945;
        wait_done(4000, "overrun_frame_done");
        check("overrun_accepted", 64'(acc_cnt), 64'(F));
        check("overrun_raddr_park", 64'(buffer_raddr_o), 64'd300);
        check("overrun_set", 64'(overrun_o), 64'(OVR_EXP));
        repeat (20) @(negedge mclk);
        check("overrun_sticky", 64'(overrun_o), 64'(OVR_EXP));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
